counter_bank: RTL and testbench
===============================

# counter_bank

Parametrised multi-channel event counter bank with 32-bit word access. It generalises the single free-running counter into CHANNELS independent counters of WIDTH bits. Each counter has per-channel increment and inhibit, wrap or saturate mode, and sticky overflow flags. Software can load and read each counter a 32-bit word at a time. The block sits beside the pipeline's CSR unit and backs cycle, retired-instruction and hazard/stall performance counters.

## Interface
- WIDTH, 64, counter width in bits; legal range 1..64.
- CHANNELS, 4, number of independent counters; legal range 1..16.
- SATURATE, 0, overflow mode: 0 = wrap to zero, 1 = hold at all-ones.
- PRESET, 0, reset and clear value of every counter; truncated to WIDTH.
- SELW, derived as max(1, $clog2(CHANNELS)), width of the channel select fields.

- clk  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- inc  input  CHANNELS  per-channel increment request, one count per cycle
- inhibit  input  CHANNELS  per-channel count inhibit; when 1, inc is ignored
- clr  input  1  synchronous clear of all counters to PRESET and all ovf to 0
- wr_en  input  1  word write strobe
- wr_sel  input  SELW  channel to write
- wr_hi  input  1  0 = write bits [31:0]; 1 = write bits [WIDTH-1:32]
- wr_data  input  32  write data; truncated to the target field width
- rd_sel  input  SELW  channel to read
- rd_hi  input  1  0 = read bits [31:0]; 1 = read bits [WIDTH-1:32], zero-extended
- rd_data  output  32  registered read data
- ovf  output  CHANNELS  sticky per-channel overflow flags

## Operation
- Per channel i, an increment is effective when inc[i] && !inhibit[i].
- Wrap mode: on an effective increment, cnt <= cnt + 1 modulo 2^WIDTH. When cnt was all-ones, cnt becomes 0 and ovf[i] is set.
- Saturate mode: when cnt is all-ones, cnt holds and an effective increment sets ovf[i]. Otherwise cnt increments by 1.
- Word write to a channel:
  - wr_hi=0 replaces bits [min(WIDTH,32)-1:0] and leaves higher bits unchanged.
  - wr_hi=1 replaces bits [WIDTH-1:32] and leaves lower bits unchanged.
  - wr_hi=1 with WIDTH<=32 is a no-op; it still clears ovf for that channel and still overrides that channel's increment.
- Any write to channel i clears ovf[i] in the same edge.
- A write with wr_sel >= CHANNELS is ignored entirely.
- A read with rd_sel >= CHANNELS returns 0. rd_hi=1 with WIDTH<=32 returns 0.
- Priority per channel, highest first:
  1. resetn low
  2. clr
  3. write to this channel
  4. effective increment
  5. hold
- When a write and an effective increment hit the same channel in the same cycle, the write wins and the increment is dropped; no partial add is applied.
- Channels not addressed by wr_sel keep counting normally during a write.
- Counting is a full WIDTH-bit increment. The carry out of bit 31 propagates into the upper word in the same cycle; there is no word-split carry delay.

## Timing
- Reset (resetn=0 at a clk edge): every counter = PRESET, ovf = 0, rd_data = 0. inc, wr_en and clr are ignored during that edge.
- Increment latency: the counter shows the new value one edge after inc is sampled.
- Write latency: the counter holds the new value one edge after wr_en is sampled.
- Read latency: one cycle. rd_data at edge N+1 reflects the rd_sel/rd_hi presented at edge N and the counter value before edge N's update.
- Same-cycle read and write of the same channel returns the old value. The written value is visible on a read issued the following cycle.
- rd_data updates every cycle; there is no read enable.
- ovf is a direct register output. It asserts one edge after the overflowing increment and stays set until a write to that channel, clr, or reset.
- Reset asserted mid-count or mid-write discards the pending operation.
- No combinational path from any input to any output.

## Test plan
- Reset: hold resetn=0 for 2 cycles with inc all-ones and wr_en=1 -> all counters = PRESET (0), ovf=0, rd_data=0 on release.
- Count and inhibit:
  - inc[0]=1 for 10 cycles; then rd_sel=0, rd_hi=0 -> rd_data=10 one cycle later.
  - Same with inhibit[1]=1 and inc[1]=1 -> channel 1 reads 0.
- Carry across words (WIDTH=64): write lo=0xFFFF_FFFF and hi=0x0, then one inc -> lo reads 0x0, hi reads 0x1, ovf[0]=0.
- Wrap versus saturate (WIDTH=8):
  - SATURATE=0: load 0xFF, one inc -> reads 0x00, ovf[0]=1.
  - SATURATE=1: load 0xFF, two incs -> reads 0xFF, ovf[0]=1.
  - In both modes, a subsequent write clears ovf[0].
- Collision:
  - Channel 2 at 5, inc[2]=1 and write lo=100 in the same cycle -> reads 100, not 101.
  - Channel 3 incrementing in that same cycle still advances.
- Clear and out-of-range (CHANNELS=4):
  - Write to wr_sel=5 -> no counter changes.
  - rd_sel=5 -> rd_data=0.
  - clr asserted together with a write and incs -> all counters = PRESET, ovf=0.

Source files
------------

// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent WIDTH-bit event counters with
// inc/inhibit, wrap or saturate, sticky ovf, 32-bit word load/read.
// Ports: clk, resetn (sync, active-low), inc, inhibit, clr,
//   wr_en/wr_sel/wr_hi/wr_data, rd_sel/rd_hi -> rd_data (registered), ovf.
module counter_bank #(
  parameter int          WIDTH    = 64,
  parameter int          CHANNELS = 4,
  parameter bit          SATURATE = 1'b0,
  parameter logic [63:0] PRESET   = 64'd0,
  localparam int         SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] inc,
  input  logic [CHANNELS-1:0] inhibit,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [SELW-1:0]     wr_sel,
  input  logic                wr_hi,
  input  logic [31:0]         wr_data,
  input  logic [SELW-1:0]     rd_sel,
  input  logic                rd_hi,
  output logic [31:0]         rd_data,
  output logic [CHANNELS-1:0] ovf
);

  localparam logic [63:0] LO_M = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] HI_M = 64'hFFFF_FFFF_0000_0000;
  localparam logic [WIDTH-1:0] PRE = WIDTH'(PRESET);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0]    cnt   [CHANNELS];
  logic [WIDTH-1:0]    cnt_n [CHANNELS];
  logic [CHANNELS-1:0] ovf_n;
  logic [63:0]         wm;
  logic [63:0]         wd;
  logic [63:0]         r64;
  logic [31:0]         rd_n;

  always_comb begin
    // Word writes merge in a 64-bit frame, then truncate to WIDTH;
    // a high-word write on a narrow counter masks to nothing.
    wm = wr_hi ? HI_M : LO_M;
    wd = wr_hi ? {wr_data, 32'h0} : {32'h0, wr_data};
    ovf_n = ovf;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_n[i] = cnt[i];
      if (wr_en && wr_sel == SELW'(i)) begin
        cnt_n[i] = WIDTH'((64'(cnt[i]) & ~wm) | (wd & wm));
        ovf_n[i] = 1'b0;
      end else if (inc[i] && !inhibit[i]) begin
        if (cnt[i] == ONES) begin
          ovf_n[i] = 1'b1;
          cnt_n[i] = SATURATE ? ONES : '0;
        end else begin
          cnt_n[i] = cnt[i] + WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    r64 = 64'h0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SELW'(i)) r64 = 64'(cnt[i]);
    end
    rd_n = rd_hi ? r64[63:32] : r64[31:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= PRE;
      ovf     <= '0;
      rd_data <= 32'h0;
    end else begin
      rd_data <= rd_n;
      if (clr) begin
        for (int i = 0; i < CHANNELS; i++) cnt[i] <= PRE;
        ovf <= '0;
      end else begin
        for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_n[i];
        ovf <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: directed checks of a 64-bit x5 bank plus a pair of
// 8-bit banks (wrap and saturate) sharing one stimulus.
module tb_counter_bank;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  inc, inhibit;
  logic        clr, wr_en, wr_hi, rd_hi;
  logic [2:0]  wr_sel, rd_sel;
  logic [31:0] wr_data, rd_data;
  logic [4:0]  ovf;

  logic [1:0]  s_inc;
  logic        s_wr_en, s_wr_hi, s_rd_hi;
  logic [0:0]  s_wr_sel, s_rd_sel;
  logic [31:0] s_wr_data, w_rd, t_rd;
  logic [1:0]  w_ovf, t_ovf;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  counter_bank #(.WIDTH(64), .CHANNELS(5), .SATURATE(1'b0)) u_main (
    .clk(clk), .resetn(resetn), .inc(inc), .inhibit(inhibit),
    .clr(clr), .wr_en(wr_en), .wr_sel(wr_sel), .wr_hi(wr_hi),
    .wr_data(wr_data), .rd_sel(rd_sel), .rd_hi(rd_hi),
    .rd_data(rd_data), .ovf(ovf)
  );

  counter_bank #(.WIDTH(8), .CHANNELS(2), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .resetn(resetn), .inc(s_inc), .inhibit(2'b00),
    .clr(1'b0), .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_hi(s_wr_hi),
    .wr_data(s_wr_data), .rd_sel(s_rd_sel), .rd_hi(s_rd_hi),
    .rd_data(w_rd), .ovf(w_ovf)
  );

  counter_bank #(.WIDTH(8), .CHANNELS(2), .SATURATE(1'b1)) u_sat (
    .clk(clk), .resetn(resetn), .inc(s_inc), .inhibit(2'b00),
    .clr(1'b0), .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_hi(s_wr_hi),
    .wr_data(s_wr_data), .rd_sel(s_rd_sel), .rd_hi(s_rd_hi),
    .rd_data(t_rd), .ovf(t_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic hi,
                    input logic [31:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_hi = hi; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel, input logic hi,
                    output logic [31:0] v);
    rd_sel = sel; rd_hi = hi;
    step();
    v = rd_data;
  endtask

  task automatic swr(input logic hi, input logic [31:0] d);
    s_wr_en = 1'b1; s_wr_sel = 1'b0; s_wr_hi = hi; s_wr_data = d;
    step();
    s_wr_en = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    resetn = 1'b0; inc = '1; inhibit = '0; clr = 1'b0;
    wr_en = 1'b1; wr_sel = 3'd0; wr_hi = 1'b0; wr_data = 32'hFFFF_FFFF;
    rd_sel = 3'd0; rd_hi = 1'b0;
    s_inc = '1; s_wr_en = 1'b1; s_wr_sel = 1'b0; s_wr_hi = 1'b0;
    s_wr_data = 32'hFF; s_rd_sel = 1'b0; s_rd_hi = 1'b0;
    step(); step();
    check("rst_rd", rd_data, 0);
    check("rst_ovf", ovf, 0);
    resetn = 1'b1; inc = '0; wr_en = 1'b0; s_inc = '0; s_wr_en = 1'b0;
    rd(3'd0, 1'b0, v); check("rst_c0", v, 0);
    rd(3'd4, 1'b1, v); check("rst_c4hi", v, 0);
    check("rst_wrap", w_rd, 0);

    // count ten, inhibited channel stays put
    inc = 5'b00011; inhibit = 5'b00010;
    repeat (10) step();
    inc = '0; inhibit = '0;
    rd(3'd0, 1'b0, v); check("cnt10", v, 10);
    rd(3'd1, 1'b0, v); check("inhib", v, 0);

    // carry from low into high word
    wr(3'd0, 1'b0, 32'hFFFF_FFFF);
    wr(3'd0, 1'b1, 32'h0);
    inc = 5'b00001; step(); inc = '0;
    rd(3'd0, 1'b0, v); check("carry_lo", v, 0);
    rd(3'd0, 1'b1, v); check("carry_hi", v, 1);
    check("carry_ovf", ovf, 0);

    // full 64-bit wrap, then write clears ovf
    wr(3'd4, 1'b0, 32'hFFFF_FFFF);
    wr(3'd4, 1'b1, 32'hFFFF_FFFF);
    inc = 5'b10000; step(); inc = '0;
    check("wrap64_ovf", ovf, 5'b10000);
    rd(3'd4, 1'b1, v); check("wrap64_hi", v, 0);
    wr(3'd4, 1'b0, 32'd5);
    check("wr_clr_ovf", ovf, 0);

    // write beats increment on the same channel
    wr(3'd2, 1'b0, 32'd5);
    inc = 5'b01100;
    wr(3'd2, 1'b0, 32'd100);
    inc = '0;
    rd(3'd2, 1'b0, v); check("coll_wr", v, 100);
    rd(3'd3, 1'b0, v); check("coll_other", v, 1);

    // same-cycle read/write returns the old value
    rd_sel = 3'd3; rd_hi = 1'b0;
    wr(3'd3, 1'b0, 32'h77);
    check("rw_old", rd_data, 1);
    rd(3'd3, 1'b0, v); check("rw_new", v, 32'h77);

    // out-of-range write and read
    wr(3'd5, 1'b0, 32'hDEAD);
    rd(3'd2, 1'b0, v); check("oor_c2", v, 100);
    rd(3'd0, 1'b1, v); check("oor_c0", v, 1);
    rd(3'd5, 1'b0, v); check("oor_rd5", v, 0);
    rd(3'd3, 1'b0, v); check("oor_c3", v, 32'h77);
    rd(3'd7, 1'b1, v); check("oor_rd7", v, 0);

    // 8-bit wrap versus saturate
    s_rd_sel = 1'b0; s_rd_hi = 1'b0;
    swr(1'b0, 32'hFF);
    s_inc = 2'b01; step(); s_inc = '0;
    step();
    check("w8_val", w_rd, 32'h00);
    check("w8_ovf", w_ovf, 2'b01);
    check("s8_val", t_rd, 32'hFF);
    check("s8_ovf", t_ovf, 2'b01);
    s_inc = 2'b01; step(); s_inc = '0;
    step();
    check("w8_val2", w_rd, 32'h01);
    check("w8_sticky", w_ovf, 2'b01);
    check("s8_hold", t_rd, 32'hFF);
    swr(1'b0, 32'h10);
    check("w8_wrclr", w_ovf, 0);
    check("s8_wrclr", t_ovf, 0);

    // hi write on a narrow counter: no-op, clears ovf, drops inc
    swr(1'b0, 32'hFF);
    s_inc = 2'b01; step();
    check("w8_ovf_b", w_ovf, 2'b01);
    swr(1'b1, 32'hFFFF);
    s_inc = '0;
    check("w8_hiovf", w_ovf, 0);
    check("s8_hiovf", t_ovf, 0);
    step();
    check("w8_hival", w_rd, 32'h00);
    check("s8_hival", t_rd, 32'hFF);
    s_rd_hi = 1'b1; step();
    check("w8_rdhi", w_rd, 0);

    // clear wins over write and increments
    wr(3'd4, 1'b0, 32'hFFFF_FFFF);
    wr(3'd4, 1'b1, 32'hFFFF_FFFF);
    inc = 5'b10000; step(); inc = '0;
    check("pre_clr_ovf", ovf, 5'b10000);
    clr = 1'b1; inc = '1;
    wr(3'd1, 1'b0, 32'h55);
    clr = 1'b0; inc = '0;
    check("clr_ovf", ovf, 0);
    rd(3'd0, 1'b1, v); check("clr_c0hi", v, 0);
    rd(3'd1, 1'b0, v); check("clr_c1", v, 0);
    rd(3'd3, 1'b0, v); check("clr_c3", v, 0);
    rd(3'd4, 1'b0, v); check("clr_c4", v, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
